// File: rtl/brq_mdu_iter.sv
// Iterative radix-2 RV32M multiply/divide unit for the Buraq execute stage.
// One start handshake per op; the tagged result is held until the write-back side acks it.
module brq_mdu_iter #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned RegAddrWidth = 5
) (
  input  logic                    brq_clk,
  input  logic                    brq_rst,
  input  logic                    mdu_start,
  input  logic [2:0]              mdu_func3,
  input  logic [DataWidth-1:0]    mdu_op_a,
  input  logic [DataWidth-1:0]    mdu_op_b,
  input  logic [RegAddrWidth-1:0] mdu_addr_dst,
  input  logic                    mdu_flush,
  input  logic                    mdu_ack,
  output logic                    mdu_ready,
  output logic                    mdu_valid,
  output logic [DataWidth-1:0]    mdu_result,
  output logic [RegAddrWidth-1:0] mdu_res_addr_dst,
  output logic                    mdu_stall
);

  localparam int unsigned AccWidth = 2 * DataWidth;
  localparam int unsigned CntWidth = $clog2(DataWidth);
  localparam logic [DataWidth-1:0] MinNeg = {1'b1, {(DataWidth-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;

  state_e                  state_q;
  logic [CntWidth-1:0]     cnt_q;
  logic [2:0]              func3_q;
  logic [RegAddrWidth-1:0] tag_q;
  logic [RegAddrWidth-1:0] res_tag_q;
  logic                    sign_a_q;
  logic                    sign_b_q;
  logic [DataWidth-1:0]    opd_q;
  logic [DataWidth-1:0]    res_q;
  logic [AccWidth-1:0]     acc_q;
  logic                    valid_q;

  logic                    a_signed_c;
  logic                    b_signed_c;
  logic                    sign_a_c;
  logic                    sign_b_c;
  logic                    fast_zero_c;
  logic                    fast_ovf_c;
  logic [DataWidth-1:0]    mag_a_c;
  logic [DataWidth-1:0]    mag_b_c;

  // Operand decode at accept: signedness per func3, magnitudes and divide fast paths
  always_comb begin
    a_signed_c  = (mdu_func3 == 3'b001) || (mdu_func3 == 3'b010) ||
                  (mdu_func3 == 3'b100) || (mdu_func3 == 3'b110);
    b_signed_c  = (mdu_func3 == 3'b001) || (mdu_func3 == 3'b100) || (mdu_func3 == 3'b110);
    sign_a_c    = a_signed_c && mdu_op_a[DataWidth-1];
    sign_b_c    = b_signed_c && mdu_op_b[DataWidth-1];
    mag_a_c     = sign_a_c ? (~mdu_op_a + DataWidth'(1)) : mdu_op_a;
    mag_b_c     = sign_b_c ? (~mdu_op_b + DataWidth'(1)) : mdu_op_b;
    fast_zero_c = mdu_func3[2] && (mdu_op_b == '0);
    fast_ovf_c  = mdu_func3[2] && !mdu_func3[0] && (mdu_op_a == MinNeg) && (&mdu_op_b);
  end

  logic [DataWidth:0]   mul_sum_c;
  logic [DataWidth:0]   rem_sh_c;
  logic [DataWidth+1:0] diff_c;
  logic                 q_bit_c;
  logic [AccWidth-1:0]  mul_next_c;
  logic [AccWidth-1:0]  div_next_c;

  // One iteration: multiply keeps {partial product, multiplier} and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left with a trial subtract
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[AccWidth-1:DataWidth]} + {1'b0, opd_q};
    mul_next_c = acc_q[0] ? {mul_sum_c, acc_q[DataWidth-1:1]} : {1'b0, acc_q[AccWidth-1:1]};
    rem_sh_c   = {acc_q[AccWidth-1:DataWidth], acc_q[DataWidth-1]};
    diff_c     = {1'b0, rem_sh_c} - {2'b00, opd_q};
    q_bit_c    = ~diff_c[DataWidth+1];
    div_next_c = {(q_bit_c ? diff_c[DataWidth-1:0] : rem_sh_c[DataWidth-1:0]),
                  acc_q[DataWidth-2:0], q_bit_c};
  end

  logic [AccWidth-1:0]  prod_c;
  logic [DataWidth-1:0] quo_c;
  logic [DataWidth-1:0] rem_c;
  logic [DataWidth-1:0] fix_res_c;

  // Sign fix-up and result select
  always_comb begin
    prod_c    = (sign_a_q ^ sign_b_q) ? (~acc_q + AccWidth'(1)) : acc_q;
    quo_c     = (sign_a_q ^ sign_b_q) ? (~acc_q[DataWidth-1:0] + DataWidth'(1))
                                      : acc_q[DataWidth-1:0];
    rem_c     = sign_a_q ? (~acc_q[AccWidth-1:DataWidth] + DataWidth'(1))
                         : acc_q[AccWidth-1:DataWidth];
    fix_res_c = rem_c;
    case (func3_q)
      3'b000:                 fix_res_c = prod_c[DataWidth-1:0];
      3'b001, 3'b010, 3'b011: fix_res_c = prod_c[AccWidth-1:DataWidth];
      3'b100, 3'b101:         fix_res_c = quo_c;
      default:                fix_res_c = rem_c;
    endcase
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      func3_q   <= '0;
      tag_q     <= '0;
      res_tag_q <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      opd_q     <= '0;
      res_q     <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
    end else if (mdu_flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mdu_start) begin
            func3_q  <= mdu_func3;
            tag_q    <= mdu_addr_dst;
            sign_a_q <= sign_a_c;
            sign_b_q <= sign_b_c;
            // Multiply: multiplicand in opd, multiplier in the low accumulator half
            opd_q    <= mdu_func3[2] ? mag_b_c : mag_a_c;
            acc_q    <= {{DataWidth{1'b0}}, (mdu_func3[2] ? mag_a_c : mag_b_c)};
            if (fast_zero_c) begin
              res_q     <= mdu_func3[1] ? mdu_op_a : {DataWidth{1'b1}};
              res_tag_q <= mdu_addr_dst;
              state_q   <= DONE;
            end else if (fast_ovf_c) begin
              res_q     <= mdu_func3[1] ? '0 : mdu_op_a;
              res_tag_q <= mdu_addr_dst;
              state_q   <= DONE;
            end else begin
              cnt_q   <= CntWidth'(DataWidth - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= func3_q[2] ? div_next_c : mul_next_c;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end
        FIX: begin
          res_q     <= fix_res_c;
          res_tag_q <= tag_q;
          state_q   <= DONE;
        end
        DONE: begin
          valid_q <= 1'b1;
          if (valid_q && mdu_ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mdu_ready        = (state_q == IDLE);
  assign mdu_stall        = (state_q == CALC) || (state_q == FIX) ||
                            ((state_q == DONE) && !(valid_q && mdu_ack));
  assign mdu_valid        = valid_q;
  assign mdu_result       = res_q;
  assign mdu_res_addr_dst = res_tag_q;

endmodule
